// File: rtl/proc_mem_responder.sv
// proc_mem_responder: unified word memory serving the basic processor's single memory port.
// Registered one-cycle reads with write-first forwarding, a preload port, range checking and write-trace status.
module proc_mem_responder #(
   parameter int DW    = 16,
   parameter int AW    = 7,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [15:0]      i_memAddr,
   input  logic [DW-1:0]    i_memData,
   input  logic             i_memWrEnable,
   output logic [DW-1:0]    o_memData,
   input  logic             i_ldEnable,
   input  logic [AW-1:0]    i_ldAddr,
   input  logic [DW-1:0]    i_ldData,
   output logic             o_addrErr,
   output logic             o_collision,
   output logic [CNT_W-1:0] o_wrCount,
   output logic [AW-1:0]    o_lastWrAddr,
   output logic [DW-1:0]    o_lastWrData
);

   localparam int DEPTH = 2 ** AW;

   logic [DW-1:0] mem_r [DEPTH];
   logic          addr_ok_s;
   logic          wr_acc_s;
   logic [AW-1:0] rd_idx_s;
   logic [DW-1:0] rd_data_s;

   // Range decode, processor write acceptance and the write-first read value
   always_comb begin
      addr_ok_s = ((i_memAddr >> AW) == 16'd0);
      rd_idx_s  = i_memAddr[AW-1:0];
      wr_acc_s  = i_memWrEnable && addr_ok_s && !i_ldEnable;
      rd_data_s = {DW{1'b0}};
      if (!addr_ok_s) begin
         rd_data_s = {DW{1'b0}};
      end else if (i_ldEnable && (i_ldAddr == rd_idx_s)) begin
         rd_data_s = i_ldData;
      end else if (wr_acc_s) begin
         // an accepted processor write always targets the read address
         rd_data_s = i_memData;
      end else begin
         rd_data_s = mem_r[rd_idx_s];
      end
   end

   // Array storage: not cleared by reset, but frozen while reset is held
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         if (i_ldEnable) begin
            mem_r[i_ldAddr] <= i_ldData;
         end else if (wr_acc_s) begin
            mem_r[rd_idx_s] <= i_memData;
         end
      end
   end

   // Registered read data, error pulses and write-trace status
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_memData    <= {DW{1'b0}};
         o_addrErr    <= 1'b0;
         o_collision  <= 1'b0;
         o_wrCount    <= {CNT_W{1'b0}};
         o_lastWrAddr <= {AW{1'b0}};
         o_lastWrData <= {DW{1'b0}};
      end else begin
         o_memData   <= rd_data_s;
         o_addrErr   <= !addr_ok_s;
         o_collision <= i_ldEnable && i_memWrEnable;
         if (wr_acc_s) begin
            o_lastWrAddr <= rd_idx_s;
            o_lastWrData <= i_memData;
            if (o_wrCount != {CNT_W{1'b1}}) begin
               o_wrCount <= o_wrCount + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

endmodule
